imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Upstream stage of the single-cycle processor system: receives a program image as a byte stream, writes 32-bit words into instruction memory, and holds the CPU in reset until the image is verified.
- Sits between the bench/host byte source and the imem write port. Drives the CPU reset in place of a bench-generated pulse.
- Image format: 2-byte word count N (little-endian), then N×4 data bytes (each word little-endian), then 1 XOR checksum byte.

Parameters:
- DEPTH, 64, imem depth in 32-bit words; maximum legal N.
- ADDR_W, 6, imem word-address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader can accept a byte.
- imem_we  output  1  imem write strobe, one cycle per word.
- imem_addr  output  ADDR_W  imem word address.
- imem_wdata  output  32  imem write data.
- cpu_rst  output  1  active-high CPU reset; held high until load succeeds.
- done  output  1  load completed with a good checksum.
- error  output  1  load aborted on length or checksum failure.
- words_loaded  output  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, done=0, error=0, words_loaded=0, checksum accumulator=0. Imem contents are untouched.
- Byte transfer occurs only on a cycle with rx_valid && rx_ready. rx_valid while rx_ready=0 is ignored and the byte is not consumed.
- rx_ready=1 only in LEN0, LEN1, DATA and CSUM.
- State machine: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
- IDLE, DONE or ERR + start → LEN0. On that edge: clear done, error, words_loaded, byte index, word address and checksum; set cpu_rst=1.
- start is ignored in LEN0, LEN1, DATA and CSUM.
- LEN0: accept byte → N[7:0]; go to LEN1.
- LEN1: accept byte → N[15:8]. Then:
  - N > DEPTH → ERR.
  - N == 0 → CSUM.
  - otherwise → DATA.
- DATA:
  - Byte k of each word goes to bits [8k+7:8k]; every data byte is XORed into the checksum.
  - On the 4th byte of a word, the next cycle drives imem_we=1 for exactly one cycle, with imem_addr = word index and imem_wdata = assembled word. words_loaded increments on that same edge.
  - rx_ready stays high during the write cycle, so back-to-back words at one byte per cycle are legal.
  - After word N-1 is accepted → CSUM.
- CSUM: accept byte.
  - Equal to the accumulator → DONE.
  - Otherwise → ERR.
  - The final word's imem_we pulse completes regardless of the outcome.
- DONE: done=1 and cpu_rst=0 from the cycle after the checksum byte is accepted; both hold until start or reset.
- ERR: error=1, cpu_rst=1, no further writes; holds until start or reset.
- Length bytes are not included in the checksum.
- imem_addr wraps only via a new start; with N <= DEPTH it never exceeds DEPTH-1.

Test Plan:
1. start; stream 02 00 13 04 50 00 93 04 10 00 C0.
   - Required: imem_we pulses at addr 0 (wdata 0x00500413) and addr 1 (0x00100493).
   - Required: words_loaded=2, done=1, cpu_rst falls one cycle after the C0 byte.
2. Same stream with checksum 0xC1.
   - Required: both words written, error=1, done=0, cpu_rst stays 1.
3. DEPTH=64; stream 41 00 (N=65).
   - Required: ERR after the second byte, no imem_we, rx_ready=0 afterwards, remaining bytes not consumed.
4. Stream 00 00 00.
   - Required: no imem_we, words_loaded=0, done=1, cpu_rst=0.
5. Scenario 1 with rx_valid randomly deasserted for 0–3 cycles between bytes.
   - Required: identical writes and result; no byte lost or duplicated.
6. Assert rst low mid-DATA, after 5 data bytes.
   - Required: all outputs immediately at reset values, cpu_rst=1.
   - After release: start plus scenario 1 stream loads correctly; then a second start from DONE reloads and reasserts cpu_rst on the start edge.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed program image as a
// byte stream. It assembles little-endian 32-bit words and writes them into
// instruction memory. The CPU is held in reset until a load finishes with a
// good checksum.
module imem_boot_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t        state;
    logic [1:0]    byte_idx;
    logic [23:0]   word_acc;   // lower three bytes of the word being assembled
    logic [7:0]    len_lo;
    logic [CW-1:0] n_words;
    logic [7:0]    csum;
    logic [15:0]   len_full;
    logic          accept;

    // The stream is only open while a load is in progress.
    assign rx_ready = (state == LEN0) || (state == LEN1) ||
                      (state == DATA) || (state == CSUM);
    assign accept   = rx_valid && rx_ready;
    assign len_full = {rx_data, len_lo};

    // Load sequencer: one register set holds the state and all outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            byte_idx     <= 2'd0;
            word_acc     <= 24'd0;
            len_lo       <= 8'd0;
            n_words      <= '0;
            csum         <= 8'd0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            // The write strobe is a single-cycle pulse.
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= LEN0;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        byte_idx     <= 2'd0;
                        imem_addr    <= '0;
                        csum         <= 8'd0;
                        cpu_rst      <= 1'b1;
                    end
                end
                LEN0: begin
                    if (accept) begin
                        len_lo <= rx_data;
                        state  <= LEN1;
                    end
                end
                LEN1: begin
                    if (accept) begin
                        if (len_full > 16'(DEPTH)) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else if (len_full == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            // Fits: length has already been bounded by DEPTH.
                            n_words <= CW'(len_full);
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum     <= csum ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx != 2'd3) begin
                            word_acc[{byte_idx, 3'b000} +: 8] <= rx_data;
                        end else begin
                            // Fourth byte completes the word; write it out
                            // while the stream keeps flowing.
                            imem_we      <= 1'b1;
                            imem_addr    <= words_loaded[ADDR_W-1:0];
                            imem_wdata   <= {rx_data, word_acc};
                            words_loaded <= words_loaded + ONE;
                            if (words_loaded + ONE == n_words) begin
                                state <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (rx_data == csum) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
